nn_sram_port_arbiter: RTL and testbench
=======================================

// Module: nn_sram_port_arbiter
// PURPOSE
//  Shares one port of a dpram32x32_cb kernel/weight SRAM between two masters: the host loader
//  (single-beat writes during learn) and the inference sequencer (multi-beat read bursts feeding
//  CNeuron/FCNeuron). Drives the active-low SRAM strobes (CSB/WEB/OEB) and the address.
//  Reads have priority. A write-starvation counter forces one write in between burst beats.
// PARAMETERS
//  ADDR_W    5   SRAM address width; burst addresses wrap modulo 2**ADDR_W
//  DATA_W    32  SRAM data width
//  LEN_W     5   burst length field width; beats = rd_len+1 (1..2**LEN_W)
//  MAX_WAIT  4   cycles a pending write may wait before it preempts a read burst (>=1)
// PORTS
//  clk       in   1       clock; SRAM CEB is tied to the same clk
//  rst       in   1       asynchronous, active-low reset
//  rd_req    in   1       burst request; held until rd_gnt
//  rd_addr   in   ADDR_W  first burst address, captured on rd_gnt
//  rd_len    in   LEN_W   beats-1, captured on rd_gnt
//  rd_gnt    out  1       1-cycle pulse: burst accepted
//  rd_valid  out  1       rd_data holds a valid beat
//  rd_data   out  DATA_W  read beat, combinational from mem_o
//  rd_done   out  1       pulses together with the last rd_valid of a burst
//  wr_valid  in   1       write request
//  wr_addr   in   ADDR_W  write address
//  wr_data   in   DATA_W  write data
//  wr_ready  out  1       combinational; write accepted when wr_valid&&wr_ready
//  mem_a     out  ADDR_W  SRAM address (registered)
//  mem_csb   out  1       chip select, active low (registered)
//  mem_web   out  1       write enable, active low (registered)
//  mem_oeb   out  1       output enable, active low (registered)
//  mem_i     out  DATA_W  SRAM write data (registered)
//  mem_o     in   DATA_W  SRAM read data; valid 1 cycle after the read strobe
//  busy      out  1       state != IDLE
// BEHAVIOUR
//  Reset (rst=0): state=IDLE; mem_csb=mem_web=mem_oeb=1; mem_a=0; mem_i=0; rd_gnt=rd_valid=0;
//   rd_done=wr_ready=busy=0; wait_cnt=0. A reset during a burst abandons it: no rd_done is issued,
//   and rd_valid drops immediately.
//  States: IDLE, RD (read beat on the port), WR (write on the port), WRI (interleaved write in a burst).
//  Arbitration runs in IDLE and WR (decision cycle T):
//   - wr_valid && (!rd_req || wait_cnt>=MAX_WAIT) -> wr_ready=1 and capture wr_addr/wr_data;
//     next state=WR.
//   - else if rd_req: rd_gnt=1, capture rd_addr/rd_len, beat index i=0; next state=RD.
//   - else next state=IDLE.
//  Port drive: RD: csb=0, oeb=0, web=1, mem_a=(base+i) mod 2**ADDR_W. WR/WRI: csb=0, web=0, oeb=1,
//   mem_a and mem_i from the captured write. IDLE: all strobes 1, mem_a holds its value.
//  Read timing: grant at T; beat k strobe at T+1+k; rd_valid at T+2+k. rd_done coincides with the
//   final rd_valid. rd_valid is registered, one cycle after each RD strobe.
//  In RD at beat i:
//   - if wr_valid && wait_cnt>=MAX_WAIT && i!=last: wr_ready=1; next=WRI; i is held.
//   - else if i==last: next=IDLE.
//   - else i++.
//   WRI always returns to RD with beat i+1. The burst address sequence is unchanged.
//  A write may preempt a burst at most once per MAX_WAIT cycles. A burst with rd_len=0 is never
//   interrupted.
//  wait_cnt counts every cycle in which wr_valid=1 and wr_ready=0. It saturates at MAX_WAIT and
//   clears when a write is accepted or when wr_valid=0.
//  Back-to-back writes stream one per cycle (WR->WR) while rd_req=0.
//  With rd_req and wr_valid both high and wait_cnt<MAX_WAIT, the read wins.
//  A simultaneous read/write to the same address has no hazard: the port is exclusive, and order
//   follows grant order.
// TESTING
//  1 Reset checks: assert rst=0 mid-burst -> all strobes 1, rd_valid=0, busy=0 async; no rd_done.
//  2 Single read: rd_req, addr=3, len=2 -> strobes at a=3,4,5 on T+1..T+3; rd_valid T+2..T+4;
//    rd_done at T+4.
//  3 Wrap: addr=30, len=3 -> mem_a 30,31,0,1; four rd_valid beats with matching mem_o data.
//  4 Write stream: 4 writes with rd_req=0 -> wr_ready every cycle; WEB low 4 consecutive cycles.
//    Readback matches.
//  5 Starvation: burst len=15 with wr_valid held from T+1 and MAX_WAIT=4 -> exactly one WRI slot
//    mid-burst. All 16 reads are delivered in order, and the burst address sequence is unbroken.
//  6 Tie: rd_req and wr_valid both rise together from IDLE -> rd_gnt first; write served
//    per the wait rules.

Source files
------------

// File: rtl/nn_sram_port_arbiter.sv
// Single-port SRAM arbiter: host writes and inference read bursts share one dpram port.
// Reads win unless a write has waited MAX_WAIT cycles, which then steals one slot mid-burst.
module nn_sram_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_done,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_csb,
    output logic              mem_web,
    output logic              mem_oeb,
    output logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] mem_o,
    output logic              busy
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, RD, WR, WRI} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic [LEN_W-1:0]    last_reg, last_next;
    logic [LEN_W-1:0]    beat_reg, beat_next;
    logic [WAIT_W-1:0]   wait_reg, wait_next;
    logic [ADDR_W-1:0]   a_reg, a_next;
    logic [DATA_W-1:0]   i_reg, i_next;
    logic                csb_reg, csb_next;
    logic                web_reg, web_next;
    logic                oeb_reg, oeb_next;
    logic                valid_reg, done_reg, done_next;
    logic                starved;

    assign starved = (wait_reg >= WAIT_MAX);

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        last_next  = last_reg;
        beat_next  = beat_reg;
        a_next     = a_reg;
        i_next     = i_reg;
        csb_next   = 1'b1;
        web_next   = 1'b1;
        oeb_next   = 1'b1;
        rd_gnt     = 1'b0;
        wr_ready   = 1'b0;
        done_next  = 1'b0;

        case (state_reg)
            IDLE, WR: begin
                if (wr_valid && (!rd_req || starved)) begin
                    wr_ready   = 1'b1;
                    state_next = WR;
                end else if (rd_req) begin
                    rd_gnt     = 1'b1;
                    base_next  = rd_addr;
                    last_next  = rd_len;
                    beat_next  = '0;
                    state_next = RD;
                end else begin
                    state_next = IDLE;
                end
            end
            RD: begin
                // The final beat is never preempted, so a 1-beat burst cannot be split.
                if (wr_valid && starved && (beat_reg != last_reg)) begin
                    wr_ready   = 1'b1;
                    state_next = WRI;
                end else if (beat_reg == last_reg) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    beat_next  = beat_reg + LEN_W'(1);
                end
            end
            WRI: begin
                beat_next  = beat_reg + LEN_W'(1);
                state_next = RD;
            end
            default: state_next = IDLE;
        endcase

        // Strobes are registered, so they are computed for the state being entered.
        case (state_next)
            RD: begin
                csb_next = 1'b0;
                oeb_next = 1'b0;
                a_next   = base_next + ADDR_W'(beat_next);
            end
            WR, WRI: begin
                csb_next = 1'b0;
                web_next = 1'b0;
                a_next   = wr_addr;
                i_next   = wr_data;
            end
            default: ;
        endcase

        if (!wr_valid || wr_ready)
            wait_next = '0;
        else if (!starved)
            wait_next = wait_reg + WAIT_W'(1);
        else
            wait_next = wait_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            last_reg  <= '0;
            beat_reg  <= '0;
            wait_reg  <= '0;
            a_reg     <= '0;
            i_reg     <= '0;
            csb_reg   <= 1'b1;
            web_reg   <= 1'b1;
            oeb_reg   <= 1'b1;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            last_reg  <= last_next;
            beat_reg  <= beat_next;
            wait_reg  <= wait_next;
            a_reg     <= a_next;
            i_reg     <= i_next;
            csb_reg   <= csb_next;
            web_reg   <= web_next;
            oeb_reg   <= oeb_next;
            valid_reg <= (state_reg == RD);
            done_reg  <= done_next;
        end
    end

    assign mem_a    = a_reg;
    assign mem_i    = i_reg;
    assign mem_csb  = csb_reg;
    assign mem_web  = web_reg;
    assign mem_oeb  = oeb_reg;
    assign rd_valid = valid_reg;
    assign rd_done  = done_reg;
    assign rd_data  = mem_o;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_nn_sram_port_arbiter.sv
// Directed bench for nn_sram_port_arbiter with a behavioural single-port SRAM model.
module tb_nn_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [4:0]  rd_len = '0;
    logic        rd_gnt, rd_valid, rd_done, wr_ready, busy;
    logic [31:0] rd_data;
    logic        wr_valid = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  mem_a;
    logic        mem_csb, mem_web, mem_oeb;
    logic [31:0] mem_i;
    logic [31:0] mem_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] sram    [32];
    logic [31:0] exp_mem [32];

    typedef struct packed {
        logic        gnt, csb, web, oeb, vld, done, wrdy;
        logic [4:0]  a;
        logic [31:0] i, d;
    } rec_t;
    rec_t rec [0:31];

    always #5 clk = ~clk;

    nn_sram_port_arbiter #(.ADDR_W(5), .DATA_W(32), .LEN_W(5), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_a(mem_a), .mem_csb(mem_csb), .mem_web(mem_web), .mem_oeb(mem_oeb),
        .mem_i(mem_i), .mem_o(mem_o), .busy(busy)
    );

    function automatic logic [31:0] pattern(input int idx);
        return 32'hA5A5_0000 + 32'(idx);
    endfunction

    // SRAM: write on a write strobe, read data one cycle after a read strobe.
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) sram[k] <= pattern(k);
            mem_o <= '0;
        end else begin
            if (!mem_csb && !mem_web) sram[mem_a] <= mem_i;
            if (!mem_csb && !mem_oeb) mem_o <= sram[mem_a];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int n);
        rec[n].gnt  = rd_gnt;
        rec[n].csb  = mem_csb;
        rec[n].web  = mem_web;
        rec[n].oeb  = mem_oeb;
        rec[n].vld  = rd_valid;
        rec[n].done = rd_done;
        rec[n].wrdy = wr_ready;
        rec[n].a    = mem_a;
        rec[n].i    = mem_i;
        rec[n].d    = rd_data;
    endtask

    // Issues one burst request at cycle 0 (grant cycle T) and records ncyc cycles.
    // If wr_start >= 0, wr_valid rises at that cycle and is held until accepted.
    task automatic run_burst(input logic [4:0] addr, input logic [4:0] len, input int wr_start,
                             input logic [4:0] waddr, input logic [31:0] wdata, input int ncyc);
        logic wdone;
        wdone = 1'b0;
        cyc();
        rd_req = 1'b1; rd_addr = addr; rd_len = len;
        wr_addr = waddr; wr_data = wdata; wr_valid = (wr_start == 0);
        #1; snap(0);
        for (int n = 1; n < ncyc; n++) begin
            cyc();
            if (rec[n-1].gnt) rd_req = 1'b0;
            if (wr_valid && rec[n-1].wrdy) begin
                wr_valid = 1'b0;
                wdone = 1'b1;
            end else if (n == wr_start && !wdone) begin
                wr_valid = 1'b1;
            end
            #1; snap(n);
        end
        rd_req = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        repeat (2) cyc();
        #1;
        checks++; if ({mem_csb, mem_web, mem_oeb} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b expected 111", {mem_csb, mem_web, mem_oeb}); end
        checks++; if (mem_a !== 5'd0 || mem_i !== 32'd0) begin errors++; $display("FAIL reset_addr_data: got a=%0d i=%h expected 0/0", mem_a, mem_i); end
        checks++; if ({rd_gnt, rd_valid, rd_done, wr_ready, busy} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {rd_gnt, rd_valid, rd_done, wr_ready, busy}); end
        cyc(); rst = 1'b1;
        cyc(); rd_req = 1'b1; rd_addr = 5'd0; rd_len = 5'd7;
        #1;
        checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL reset_pre_gnt: got %b expected 1", rd_gnt); end
        cyc(); rd_req = 1'b0;
        cyc(); cyc();
        #1;
        checks++; if ({rd_valid, busy} !== 2'b11) begin errors++; $display("FAIL reset_midburst_pre: got valid,busy=%b expected 11", {rd_valid, busy}); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({mem_csb, mem_web, mem_oeb} !== 3'b111) begin errors++; $display("FAIL reset_async_strobes: got %b expected 111", {mem_csb, mem_web, mem_oeb}); end
        checks++; if ({rd_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_async_flags: got valid,busy=%b expected 00", {rd_valid, busy}); end
        seen = 0;
        repeat (2) begin cyc(); #1; if (rd_done || rd_valid) seen++; end
        rst = 1'b1;
        repeat (12) begin cyc(); #1; if (rd_done || rd_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_no_done: got %0d valid/done cycles expected 0", seen); end
        $display("test_reset: done");
    endtask

    task automatic test_single_read();
        run_burst(5'd3, 5'd2, -1, 5'd0, 32'd0, 8);
        checks++; if (rec[0].gnt !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b expected 1", rec[0].gnt); end
        for (int n = 1; n < 8; n++) begin
            logic [2:0] es;
            es = (n <= 3) ? 3'b010 : 3'b111;
            checks++; if ({rec[n].csb, rec[n].web, rec[n].oeb} !== es) begin errors++; $display("FAIL single_strobe c%0d: got %b expected %b", n, {rec[n].csb, rec[n].web, rec[n].oeb}, es); end
            if (n <= 3) begin checks++; if (rec[n].a !== 5'(n + 2)) begin errors++; $display("FAIL single_addr c%0d: got %0d expected %0d", n, rec[n].a, n + 2); end end
            checks++; if ({rec[n].vld, rec[n].done} !== {(n >= 2 && n <= 4), (n == 4)}) begin errors++; $display("FAIL single_valid_done c%0d: got %b%b expected %b%b", n, rec[n].vld, rec[n].done, (n >= 2 && n <= 4), (n == 4)); end
            if (n >= 2 && n <= 4) begin checks++; if (rec[n].d !== exp_mem[n + 1]) begin errors++; $display("FAIL single_data c%0d: got %h expected %h", n, rec[n].d, exp_mem[n + 1]); end end
        end
        $display("test_single_read: addr=3 len=2");
    endtask

    task automatic test_wrap();
        logic [4:0] ea [4];
        ea[0] = 5'd30; ea[1] = 5'd31; ea[2] = 5'd0; ea[3] = 5'd1;
        run_burst(5'd30, 5'd3, -1, 5'd0, 32'd0, 8);
        for (int n = 1; n <= 4; n++) begin
            checks++; if (rec[n].oeb !== 1'b0 || rec[n].a !== ea[n-1]) begin errors++; $display("FAIL wrap_addr c%0d: got oeb=%b a=%0d expected 0/%0d", n, rec[n].oeb, rec[n].a, ea[n-1]); end
            checks++; if (rec[n+1].vld !== 1'b1 || rec[n+1].d !== exp_mem[ea[n-1]]) begin errors++; $display("FAIL wrap_data c%0d: got v=%b %h expected 1/%h", n + 1, rec[n+1].vld, rec[n+1].d, exp_mem[ea[n-1]]); end
        end
        checks++; if ({rec[5].done, rec[6].vld} !== 2'b10) begin errors++; $display("FAIL wrap_done: got done5,vld6=%b expected 10", {rec[5].done, rec[6].vld}); end
        $display("test_wrap: addr=30 len=3");
    endtask

    task automatic test_write_stream();
        int weblow;
        weblow = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k < 4) begin
                wr_valid = 1'b1; wr_addr = 5'(8 + k); wr_data = 32'hD00D_0000 + 32'(k);
            end else begin
                wr_valid = 1'b0;
            end
            #1;
            if (k < 5) begin checks++; if (wr_ready !== (k < 4)) begin errors++; $display("FAIL stream_ready k%0d: got %b expected %b", k, wr_ready, (k < 4)); end end
            if (k >= 1 && k <= 4) begin
                if (!mem_web) weblow++;
                checks++; if ({mem_csb, mem_web, mem_oeb} !== 3'b001 || mem_a !== 5'(7 + k) || mem_i !== 32'hD00D_0000 + 32'(k - 1)) begin
                    errors++; $display("FAIL stream_port k%0d: got %b a=%0d i=%h expected 001 a=%0d i=%h", k, {mem_csb, mem_web, mem_oeb}, mem_a, mem_i, 7 + k, 32'hD00D_0000 + 32'(k - 1));
                end
            end
            if (k == 5) begin checks++; if ({mem_csb, mem_web, mem_oeb} !== 3'b111) begin errors++; $display("FAIL stream_idle: got %b expected 111", {mem_csb, mem_web, mem_oeb}); end end
        end
        checks++; if (weblow !== 4) begin errors++; $display("FAIL stream_web_count: got %0d expected 4", weblow); end
        for (int k = 0; k < 4; k++) exp_mem[8 + k] = 32'hD00D_0000 + 32'(k);
        run_burst(5'd8, 5'd3, -1, 5'd0, 32'd0, 7);
        for (int n = 2; n <= 5; n++) begin
            checks++; if (rec[n].vld !== 1'b1 || rec[n].d !== exp_mem[n + 6]) begin errors++; $display("FAIL stream_readback c%0d: got v=%b %h expected 1/%h", n, rec[n].vld, rec[n].d, exp_mem[n + 6]); end
        end
        $display("test_write_stream: 4 writes at 8..11");
    endtask

    task automatic test_starvation();
        int wri, nd, beat;
        logic [31:0] got [$];
        logic rd, ev;
        wri = 0;
        run_burst(5'd16, 5'd15, 1, 5'd2, 32'hBEEF_0002, 22);
        for (int n = 1; n < 22; n++) begin
            rd   = (n <= 5) || (n >= 7 && n <= 17);
            beat = (n <= 5) ? n - 1 : n - 2;
            ev   = (n >= 2 && n <= 6) || (n >= 8 && n <= 18);
            if (!rec[n].web) wri++;
            if (rec[n].vld) got.push_back(rec[n].d);
            if (rd) begin
                checks++; if ({rec[n].csb, rec[n].web, rec[n].oeb} !== 3'b010 || rec[n].a !== 5'(16 + beat)) begin errors++; $display("FAIL starve_rd c%0d: got %b a=%0d expected 010 a=%0d", n, {rec[n].csb, rec[n].web, rec[n].oeb}, rec[n].a, (16 + beat) % 32); end
            end else if (n == 6) begin
                checks++; if ({rec[n].csb, rec[n].web, rec[n].oeb} !== 3'b001 || rec[n].a !== 5'd2 || rec[n].i !== 32'hBEEF_0002) begin errors++; $display("FAIL starve_wri: got %b a=%0d i=%h expected 001 a=2 i=beef0002", {rec[n].csb, rec[n].web, rec[n].oeb}, rec[n].a, rec[n].i); end
            end
            checks++; if ({rec[n].vld, rec[n].done, rec[n].wrdy} !== {ev, (n == 18), (n == 5)}) begin errors++; $display("FAIL starve_flags c%0d: got %b expected %b", n, {rec[n].vld, rec[n].done, rec[n].wrdy}, {ev, (n == 18), (n == 5)}); end
        end
        checks++; if (wri !== 1) begin errors++; $display("FAIL starve_wri_count: got %0d expected 1", wri); end
        checks++; if (got.size() !== 16) begin errors++; $display("FAIL starve_beats: got %0d expected 16", got.size()); end
        nd = (got.size() < 16) ? got.size() : 16;
        for (int j = 0; j < nd; j++) begin
            checks++; if (got[j] !== exp_mem[(16 + j) % 32]) begin errors++; $display("FAIL starve_data b%0d: got %h expected %h", j, got[j], exp_mem[(16 + j) % 32]); end
        end
        exp_mem[2] = 32'hBEEF_0002;
        $display("test_starvation: len=15 with pending write");
    endtask

    task automatic test_tie();
        run_burst(5'd4, 5'd1, 0, 5'd20, 32'h7E57_0014, 8);
        checks++; if ({rec[0].gnt, rec[0].wrdy} !== 2'b10) begin errors++; $display("FAIL tie_first: got gnt,wrdy=%b expected 10", {rec[0].gnt, rec[0].wrdy}); end
        checks++; if ({rec[1].wrdy, rec[2].wrdy, rec[3].wrdy} !== 3'b001) begin errors++; $display("FAIL tie_ready: got %b expected 001", {rec[1].wrdy, rec[2].wrdy, rec[3].wrdy}); end
        checks++; if (rec[2].d !== exp_mem[4] || rec[3].d !== exp_mem[5] || {rec[2].vld, rec[3].vld, rec[3].done} !== 3'b111) begin errors++; $display("FAIL tie_read: got %h %h expected %h %h", rec[2].d, rec[3].d, exp_mem[4], exp_mem[5]); end
        checks++; if ({rec[4].csb, rec[4].web, rec[4].oeb} !== 3'b001 || rec[4].a !== 5'd20 || rec[4].i !== 32'h7E57_0014) begin errors++; $display("FAIL tie_write: got %b a=%0d i=%h expected 001 a=20 i=7e570014", {rec[4].csb, rec[4].web, rec[4].oeb}, rec[4].a, rec[4].i); end
        exp_mem[20] = 32'h7E57_0014;
        run_burst(5'd20, 5'd0, -1, 5'd0, 32'd0, 4);
        checks++; if ({rec[1].oeb, rec[2].vld, rec[2].done, rec[3].vld} !== 4'b0110 || rec[2].d !== exp_mem[20]) begin errors++; $display("FAIL tie_readback: got %b %h expected 0110 %h", {rec[1].oeb, rec[2].vld, rec[2].done, rec[3].vld}, rec[2].d, exp_mem[20]); end
        run_burst(5'd2, 5'd0, -1, 5'd0, 32'd0, 4);
        checks++; if (rec[2].vld !== 1'b1 || rec[2].d !== exp_mem[2]) begin errors++; $display("FAIL wri_readback: got v=%b %h expected 1/%h", rec[2].vld, rec[2].d, exp_mem[2]); end
        $display("test_tie: read granted first, write follows");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 32; k++) exp_mem[k] = pattern(k);
        test_reset();
        test_single_read();
        test_wrap();
        test_write_stream();
        test_starvation();
        test_tie();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
